// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request vector and registered grant bundle between requesters and the arbiter
interface rr_arbiter8_if;
   logic [7:0] req;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       expired;
   modport master (output req, input grant_idx, grant_valid, expired);
   modport slave (input req, output grant_idx, grant_valid, expired);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with hold-while-requesting and optional max hold time
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input logic          clk,
   input logic          reset,
   rr_arbiter8_if.slave bus
);
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
   localparam bit         LIMITED = (MAX_HOLD != 0);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state, state_n;
   logic [2:0] ptr, ptr_n, grant_idx, idx_n, off, sel;
   logic       grant_valid, valid_n, expired, exp_n;
   logic [7:0] hold_cnt, hold_n, rot;
   // rotate so bit 0 is the search start; the lowest set bit is the winner
   always_comb begin
      rot = 8'({bus.req, bus.req} >> ptr);
      off = '0;
      for (int i = 7; i >= 0; i--)
         if (rot[i]) off = 3'(i);
      sel = ptr + off;
   end
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      idx_n   = grant_idx;
      valid_n = grant_valid;
      hold_n  = hold_cnt;
      exp_n   = 1'b0;
      if (state == IDLE) begin
         if (|bus.req) begin
            state_n = GRANT;
            idx_n   = sel;
            valid_n = 1'b1;
            hold_n  = 8'd1;
            ptr_n   = sel + 3'd1;
         end
      end else if (!bus.req[grant_idx]) begin
         state_n = IDLE;
         valid_n = 1'b0;
      end else if (LIMITED && hold_cnt == HOLD_MAX) begin
         state_n = IDLE;
         valid_n = 1'b0;
         exp_n   = 1'b1;
      end else begin
         hold_n = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         hold_cnt    <= '0;
         expired     <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         grant_idx   <= idx_n;
         grant_valid <= valid_n;
         hold_cnt    <= hold_n;
         expired     <= exp_n;
      end
   end
   assign bus.grant_idx   = grant_idx;
   assign bus.grant_valid = grant_valid;
   assign bus.expired     = expired;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: three arbiters (MAX_HOLD 16, 4, 0) on a shared request vector against a behavioural model
module tb_rr_arbiter8;
   localparam int MH [3] = '{16, 4, 0};
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] req = 8'h00;
   int         checks = 0;
   int         errors = 0;
   rr_arbiter8_if if0 ();
   rr_arbiter8_if if1 ();
   rr_arbiter8_if if2 ();
   assign if0.req = req;
   assign if1.req = req;
   assign if2.req = req;
   rr_arbiter8 #(.MAX_HOLD(16)) u0 (.clk(clk), .reset(reset), .bus(if0));
   rr_arbiter8 #(.MAX_HOLD(4))  u1 (.clk(clk), .reset(reset), .bus(if1));
   rr_arbiter8 #(.MAX_HOLD(0))  u2 (.clk(clk), .reset(reset), .bus(if2));
   always #5 clk = ~clk;
   logic [2:0] gi [3];
   logic       gv [3];
   logic       ge [3];
   assign gi[0] = if0.grant_idx;
   assign gi[1] = if1.grant_idx;
   assign gi[2] = if2.grant_idx;
   assign gv[0] = if0.grant_valid;
   assign gv[1] = if1.grant_valid;
   assign gv[2] = if2.grant_valid;
   assign ge[0] = if0.expired;
   assign ge[1] = if1.expired;
   assign ge[2] = if2.expired;
   // model: who owns the grant, where the next search starts, how long the owner has held it
   int m_own [3];
   int m_nxt [3];
   int m_held [3];
   bit m_busy [3];
   bit m_exp [3];
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_own[k] = 0; m_nxt[k] = 0; m_held[k] = 0; m_busy[k] = 0; m_exp[k] = 0;
      end
   endtask
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         m_exp[k] = 0;
         if (!m_busy[k]) begin
            if (req != 0) begin
               for (int j = 0; j < 8; j++)
                  if (req[(m_nxt[k] + j) % 8]) begin
                     m_own[k] = (m_nxt[k] + j) % 8;
                     break;
                  end
               m_busy[k] = 1;
               m_held[k] = 1;
               m_nxt[k]  = (m_own[k] + 1) % 8;
            end
         end else if (!req[m_own[k]]) m_busy[k] = 0;
         else if (MH[k] != 0 && m_held[k] >= MH[k]) begin
            m_busy[k] = 0;
            m_exp[k]  = 1;
         end else m_held[k]++;
      end
   endtask
   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("valid[%0d]", k), int'(gv[k]), int'(m_busy[k]));
         chk($sformatf("idx[%0d]", k), int'(gi[k]), m_own[k]);
         chk($sformatf("expired[%0d]", k), int'(ge[k]), int'(m_exp[k]));
      end
   endtask
   task automatic step();
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
      check_all();
   endtask
   // reset asserted between edges must clear outputs before any clock edge
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask
   int seq [$];
   bit prev;
   initial begin
      model_reset();
      @(negedge clk);
      check_all();
      reset = 1'b0;
      req = 8'h08;
      repeat (3) step();
      chk("held_idx3", int'(gi[0]), 3);
      do_reset();
      chk("rst_valid", int'(gv[0]), 0);
      step();
      chk("post_rst_idx3", int'(gi[0]), 3);
      chk("post_rst_valid", int'(gv[0]), 1);
      do_reset();
      req = 8'b0000_0100;
      repeat (10) step();
      chk("single_valid", int'(gv[0]), 1);
      req = 8'h00;
      step();
      chk("single_drop_valid", int'(gv[0]), 0);
      chk("single_drop_idx", int'(gi[0]), 2);
      repeat (2) step();
      do_reset();
      req = 8'hFF;
      prev = 0;
      repeat (50) begin
         step();
         if (gv[1] && !prev) seq.push_back(int'(gi[1]));
         prev = gv[1];
      end
      chk("full_load_grants", seq.size() >= 9 ? 1 : 0, 1);
      for (int i = 0; i < 9 && i < seq.size(); i++) chk($sformatf("full_seq%0d", i), seq[i], i % 8);
      do_reset();
      req = 8'h20;
      step();
      chk("wrap_idx5", int'(gi[0]), 5);
      req = 8'h00;
      step();
      req = 8'b0000_0011;
      step();
      chk("wrap_idx0", int'(gi[0]), 0);
      req = 8'h00;
      step();
      req = 8'b0000_0011;
      step();
      chk("wrap_ptr1", int'(gi[0]), 1);
      do_reset();
      req = 8'h81;
      repeat (300) begin
         step();
         chk("unlim_valid", int'(gv[2]), 1);
         chk("unlim_exp", int'(ge[2]), 0);
      end
      req = 8'h80;
      step();
      chk("unlim_gap", int'(gv[2]), 0);
      step();
      chk("unlim_next_idx7", int'(gi[2]), 7);
      chk("unlim_next_valid", int'(gv[2]), 1);
      do_reset();
      req = 8'h01;
      repeat (4) step();
      req = 8'h00;
      step();
      chk("drop_vs_exp_valid", int'(gv[1]), 0);
      chk("drop_vs_exp_exp", int'(ge[1]), 0);
      repeat (400) begin
         if ($urandom_range(63) == 0) do_reset();
         if ($urandom_range(3) == 0) req = 8'($urandom);
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
